// File: rtl/iso_tx_pkg.sv
// iso_tx_pkg: shared FSM state type, width helper and ETU sample point for the ISO 7816-3 transmitter
package iso_tx_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, ERRWAIT} state_t;

   // The error signal is sampled at (clocksPerBit+1) >> SAMPLE_SHIFT, i.e. mid-ETU
   localparam int SAMPLE_SHIFT = 1;

   function automatic int clog2w(input int n);
      return n > 1 ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/iso_tx_fifo.sv
// iso_tx_fifo: synchronous FIFO with registered full/empty and an occupancy counter one bit wider than the pointers
module iso_tx_fifo
   import iso_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                               clk,
   input  logic                               nReset,
   input  logic                               push,
   input  logic                               pop,
   input  logic [DATA_WIDTH-1:0]              data,
   output logic [DATA_WIDTH-1:0]              head,
   output logic                               full,
   output logic                               empty,
   output logic [clog2w(FIFO_DEPTH):0]        level
);
   localparam int AW = clog2w(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr, rd;
   logic [AW:0] nxt;
   logic push_ok, pop_ok;

   // A push into a full FIFO is refused even when a pop happens in the same cycle
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign nxt     = level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   assign head    = mem[rd];

   // Storage array, no reset needed: validity is tracked by the pointers
   always_ff @(posedge clk)
      if (push_ok) mem[wr] <= data;

   // Pointers wrap modulo the power-of-two depth; flags are registered from the next occupancy
   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         wr    <= '0;
         rd    <= '0;
         level <= '0;
         full  <= 1'b0;
         empty <= 1'b1;
      end else begin
         wr    <= wr + AW'(push_ok);
         rd    <= rd + AW'(pop_ok);
         level <= nxt;
         full  <= nxt == (AW+1)'(FIFO_DEPTH);
         empty <= nxt == '0;
      end

endmodule

// File: rtl/iso_tx_engine.sv
// iso_tx_engine: ISO 7816-3 character transmitter; T=0 error signal and retries when ISO_TX_ERROR_SIGNAL_EN is defined
module iso_tx_engine
   import iso_tx_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int DIVIDER_WIDTH = 13,
   parameter int FIFO_DEPTH    = 4,
   parameter int MAX_RETRIES   = 3
) (
   input  logic                     clk,
   input  logic                     nReset,
   input  logic [DATA_WIDTH-1:0]    dataIn,
   input  logic                     loadDataIn,
   input  logic [DIVIDER_WIDTH-1:0] clocksPerBit,
   input  logic                     stopBit2,
   input  logic                     oddParity,
   input  logic                     msbFirst,
   input  logic                     serialIn,
   output logic                     serialOut,
   output logic                     run,
   output logic                     full,
   output logic                     empty,
   output logic                     stopBits,
   output logic                     txError
);
   localparam int AW = clog2w(FIFO_DEPTH);
   localparam int BW = clog2w(DATA_WIDTH);
   localparam int RW = clog2w(MAX_RETRIES + 1);

   state_t state;
   logic [DIVIDER_WIDTH-1:0] cnt, cpb;
   logic [BW-1:0] bit_cnt;
   logic [DATA_WIDTH-1:0] sh, head;
   logic [AW:0] level;
   logic par, stop2, odd, msb, etu_end, pop, next_busy, begin_new, err_any;

   iso_tx_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .nReset(nReset), .push(loadDataIn), .pop(pop), .data(dataIn),
      .head(head), .full(full), .empty(empty), .level(level)
   );

   assign etu_end   = cnt == cpb;
   // After a pop the FIFO still holds a character if more than one was queued or one lands this cycle
   assign next_busy = level > (AW+1)'(1) || (loadDataIn && !full);
   assign begin_new = (state == IDLE && !empty) || (pop && next_busy);

`ifdef ISO_TX_ERROR_SIGNAL_EN
   logic err, err_hit;
   logic [RW-1:0] retry;
   assign err_hit = state == STOP && bit_cnt == '0 && !serialIn &&
                    {1'b0, cnt} == (({1'b0, cpb} + 1'b1) >> SAMPLE_SHIFT);
   assign err_any = err || err_hit;
   assign pop = (state == STOP && etu_end && bit_cnt == BW'(stop2) && !err_any) ||
                (state == ERRWAIT && etu_end && bit_cnt == BW'(1) && retry == RW'(MAX_RETRIES));
`else
   logic unused_serial;
   assign unused_serial = serialIn;
   assign err_any = 1'b0;
   assign txError = 1'b0;
   assign pop     = state == STOP && etu_end && bit_cnt == BW'(stop2);
`endif

   // Frame settings freeze when a new character begins; repeats keep the original settings
   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         cpb   <= '0;
         stop2 <= 1'b0;
         odd   <= 1'b0;
         msb   <= 1'b0;
      end else if (begin_new) begin
         cpb   <= clocksPerBit;
         stop2 <= stopBit2;
         odd   <= oddParity;
         msb   <= msbFirst;
      end

   // Frame sequencer: each state lasts whole ETUs, line drive and status are registered
   always_ff @(posedge clk or negedge nReset)
      if (!nReset) begin
         state     <= IDLE;
         serialOut <= 1'b1;
         run       <= 1'b0;
         stopBits  <= 1'b0;
         cnt       <= '0;
         bit_cnt   <= '0;
         sh        <= '0;
         par       <= 1'b0;
`ifdef ISO_TX_ERROR_SIGNAL_EN
         err       <= 1'b0;
         retry     <= '0;
         txError   <= 1'b0;
`endif
      end else begin
         cnt <= (state == IDLE || etu_end) ? '0 : cnt + 1'b1;
`ifdef ISO_TX_ERROR_SIGNAL_EN
         txError <= 1'b0;
`endif
         case (state)
            IDLE: if (!empty) begin
               state     <= START;
               serialOut <= 1'b0;
               run       <= 1'b1;
            end
            START: if (etu_end) begin
               state     <= DATA;
               bit_cnt   <= '0;
               serialOut <= msb ? head[DATA_WIDTH-1] : head[0];
               sh        <= msb ? head << 1 : head >> 1;
               par       <= ^head ^ odd;
            end
            DATA: if (etu_end) begin
               if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                  state     <= PARITY;
                  serialOut <= par;
               end else begin
                  bit_cnt   <= bit_cnt + 1'b1;
                  serialOut <= msb ? sh[DATA_WIDTH-1] : sh[0];
                  sh        <= msb ? sh << 1 : sh >> 1;
               end
            end
            PARITY: if (etu_end) begin
               state     <= STOP;
               serialOut <= 1'b1;
               stopBits  <= 1'b1;
               bit_cnt   <= '0;
`ifdef ISO_TX_ERROR_SIGNAL_EN
               err       <= 1'b0;
`endif
            end
            STOP: begin
`ifdef ISO_TX_ERROR_SIGNAL_EN
               if (err_hit) err <= 1'b1;
`endif
               if (etu_end) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  if (err_any) begin
                     state    <= ERRWAIT;
                     stopBits <= 1'b0;
                     bit_cnt  <= '0;
                  end
               end
            end
`ifdef ISO_TX_ERROR_SIGNAL_EN
            ERRWAIT: if (etu_end) begin
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == BW'(1)) begin
                  if (retry < RW'(MAX_RETRIES)) begin
                     retry     <= retry + 1'b1;
                     state     <= START;
                     serialOut <= 1'b0;
                  end else txError <= 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
         if (pop) begin
            state     <= next_busy ? START : IDLE;
            serialOut <= !next_busy;
            run       <= next_busy;
            stopBits  <= 1'b0;
`ifdef ISO_TX_ERROR_SIGNAL_EN
            retry     <= '0;
`endif
         end
      end

endmodule

// File: tb/tb_iso_tx_engine.sv
// tb_iso_tx_engine: directed and randomized frame checks against a per-ETU line model of the transmitter
module tb_iso_tx_engine;
   localparam int MAXR = 3;

   typedef struct {
      logic lvl;
      logic stp;
      logic low;
      logic tx;
   } etu_t;

   logic clk = 1'b0, nReset = 1'b0, loadDataIn = 1'b0, serialIn = 1'b1;
   logic stopBit2 = 1'b0, oddParity = 1'b0, msbFirst = 1'b0;
   logic [7:0] dataIn = '0;
   logic [12:0] clocksPerBit = 13'd7;
   logic serialOut, run, full, empty, stopBits, txError;
   int vectors = 0, miscompares = 0, skip;
   logic [7:0] wq[$];
   int eq[$];

   iso_tx_engine dut (
      .clk(clk), .nReset(nReset), .dataIn(dataIn), .loadDataIn(loadDataIn),
      .clocksPerBit(clocksPerBit), .stopBit2(stopBit2), .oddParity(oddParity),
      .msbFirst(msbFirst), .serialIn(serialIn), .serialOut(serialOut), .run(run),
      .full(full), .empty(empty), .stopBits(stopBits), .txError(txError)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic add(input logic [7:0] w, input int e);
      wq.push_back(w);
      eq.push_back(e);
   endtask

   // Queue the words on consecutive cycles; leaves skip = START cycles already elapsed
   task automatic load_all(output int sk);
      foreach (wq[i]) begin
         dataIn = wq[i];
         loadDataIn = 1'b1;
         tick;
      end
      loadDataIn = 1'b0;
      chk("empty_after_load", empty, 0);
      if (wq.size() == 1) begin
         chk("latency_serialOut", serialOut, 1);
         chk("latency_run", run, 0);
         tick;
         sk = 0;
      end else sk = wq.size() - 2;
   endtask

   // Expected line per ETU: start, data, parity, stop(s); an errored send is start..first stop plus two idle ETUs
   task automatic run_frames(input int sk);
      etu_t bits[$];
      logic pend = 1'b0;
      int c = 0;
      int etu = int'(clocksPerBit) + 1;
      foreach (wq[k]) begin
         logic [7:0] w = wq[k];
         int n = eq[k] > MAXR ? MAXR + 1 : eq[k] + 1;
         for (int t = 0; t < n; t++) begin
            logic bad = t < eq[k];
            bits.push_back('{1'b0, 1'b0, 1'b0, pend});
            pend = 1'b0;
            for (int i = 0; i < 8; i++) bits.push_back('{w[msbFirst ? 7 - i : i], 1'b0, 1'b0, 1'b0});
            bits.push_back('{($countones(w) % 2 == 1) != oddParity, 1'b0, 1'b0, 1'b0});
            bits.push_back('{1'b1, 1'b1, bad, 1'b0});
            if (bad) begin
               bits.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
               bits.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
               if (t == MAXR) pend = 1'b1;
            end else if (stopBit2) bits.push_back('{1'b1, 1'b1, 1'b0, 1'b0});
         end
      end
      foreach (bits[b])
         for (int e = 0; e < etu; e++) begin
            if (c >= sk) begin
               serialIn = bits[b].low ? 1'b0 : 1'b1;
               chk("serialOut", serialOut, bits[b].lvl);
               chk("stopBits", stopBits, bits[b].stp);
               chk("run", run, 1);
               chk("txError", txError, e == 0 && bits[b].tx);
               tick;
            end
            c++;
         end
      serialIn = 1'b1;
      chk("end_serialOut", serialOut, 1);
      chk("end_run", run, 0);
      chk("end_empty", empty, 1);
      chk("end_txError", txError, pend);
      wq.delete();
      eq.delete();
   endtask

   initial begin
      tick;
      tick;
      chk("rst_serialOut", serialOut, 1);
      chk("rst_run", run, 0);
      chk("rst_full", full, 0);
      chk("rst_empty", empty, 1);
      chk("rst_stopBits", stopBits, 0);
      chk("rst_txError", txError, 0);
      nReset = 1'b1;
      tick;

      // Basic frame: 8'h80, 8-cycle ETU, even parity, LSB first
      add(8'h80, 0);
      load_all(skip);
      run_frames(skip);

      // Back-to-back: two frames without an idle gap
      add(8'h80, 0);
      add(8'h7F, 0);
      load_all(skip);
      run_frames(skip);

      // FIFO boundary: six held writes, only four are accepted and sent
      for (int i = 0; i < 6; i++) begin
         dataIn = 8'(8'h31 + i);
         loadDataIn = 1'b1;
         tick;
         chk("fifo_full", full, i >= 3);
      end
      loadDataIn = 1'b0;
      for (int i = 0; i < 4; i++) add(8'(8'h31 + i), 0);
      run_frames(4);

      // Randomized settings and bursts
      for (int r = 0; r < 10; r++) begin
         int n = $urandom_range(1, 3);
         clocksPerBit = 13'($urandom_range(0, 9));
         stopBit2 = 1'($urandom_range(0, 1));
         oddParity = 1'($urandom_range(0, 1));
         msbFirst = 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) add(8'($urandom_range(0, 255)), 0);
         load_all(skip);
         run_frames(skip);
      end

`ifdef ISO_TX_ERROR_SIGNAL_EN
      clocksPerBit = 13'd7;
      stopBit2 = 1'b0;
      oddParity = 1'b0;
      msbFirst = 1'b0;
      add(8'hA5, 1);
      load_all(skip);
      run_frames(skip);
      add(8'hA5, MAXR + 1);
      add(8'h3C, 0);
      load_all(skip);
      run_frames(skip);
`endif

      // Reset in the middle of data bit 3
      clocksPerBit = 13'd7;
      stopBit2 = 1'b0;
      oddParity = 1'b0;
      msbFirst = 1'b0;
      add(8'h55, 0);
      add(8'h12, 0);
      load_all(skip);
      repeat (36) tick;
      chk("pre_reset_serialOut", serialOut, 0);
      #1 nReset = 1'b0;
      #1;
      chk("async_serialOut", serialOut, 1);
      chk("async_run", run, 0);
      chk("async_empty", empty, 1);
      chk("async_stopBits", stopBits, 0);
      tick;
      nReset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         tick;
         chk("post_reset_serialOut", serialOut, 1);
         chk("post_reset_run", run, 0);
      end
      chk("post_reset_empty", empty, 1);
      wq.delete();
      eq.delete();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/iso_tx_engine.md
# iso_tx_engine

Parametrised ISO 7816-3 character transmitter with input FIFO and T=0 error-signal handling. Accepts characters from the host through a load/full handshake, buffers them, and serialises each as start bit, data bits, parity bit and guard/stop time on an open-drain-style I/O line. It replaces the single-buffer transmitter in the UART datapath. When the receiver signals a parity error, it automatically repeats the character.

## Interface
- DATA_WIDTH, 8, character bits per frame
- DIVIDER_WIDTH, 13, width of clocksPerBit
- FIFO_DEPTH, 4, buffered characters; power of two, ≥2
- MAX_RETRIES, 3, repetitions per character before it is dropped
- clk  in  1  system clock
- nReset  in  1  reset, asynchronous, active-low
- dataIn  in  DATA_WIDTH  character to queue
- loadDataIn  in  1  write strobe; accepted when full=0
- clocksPerBit  in  DIVIDER_WIDTH  ETU length minus one, in clk cycles
- stopBit2  in  1  1: two guard ETUs; 0: one
- oddParity  in  1  1: data+parity has odd weight
- msbFirst  in  1  1: send b[DATA_WIDTH-1] first
- serialIn  in  1  sampled line level, for error-signal detection
- serialOut  out  1  line drive; 1 = release/high
- run  out  1  frame in progress
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- stopBits  out  1  high during guard/stop ETUs
- txError  out  1  one-cycle pulse when a character is dropped after MAX_RETRIES

## Operation
- One clock domain on clk; asynchronous active-low reset on nReset.
- Write: the FIFO pushes when loadDataIn=1 and full=0. Holding loadDataIn high pushes once per cycle while not full.
- ETU = clocksPerBit+1 cycles. clocksPerBit, stopBit2, oddParity and msbFirst latch at frame start and hold for the whole frame, including repeats.
- FSM states: IDLE, START, DATA, PARITY, STOP, ERRWAIT.
- IDLE→START when the FIFO is non-empty. The head word is copied to the shift register; the FIFO is not popped yet.
- START: 1 ETU of 0.
- DATA: DATA_WIDTH ETUs, LSB or MSB first.
- PARITY: 1 ETU of ^data ^ oddParity.
- STOP: 1 or 2 ETUs of 1.
- Frame end, normal case: pop the FIFO and reset the retry counter.
- Frame end, then IDLE or START: go straight to START if the FIFO is still non-empty, with no idle cycle.
- Error signal: serialIn is sampled once, at cycle (clocksPerBit+1)/2 of the first STOP ETU. If it is low, go to ERRWAIT.
- ERRWAIT: 2 ETUs of 1, then retry.
  - If retries < MAX_RETRIES: increment the counter, go to START and resend the same word without popping.
  - Otherwise: pop, pulse txError, clear the counter.

## Timing
- Reset values: serialOut=1, run=0, full=0, empty=1, stopBits=0, txError=0. FSM is in IDLE, FIFO pointers and retry counter are 0.
- Reset mid-frame: serialOut returns to 1 immediately (asynchronous) and FIFO contents are discarded.
- Latency: loadDataIn high at edge N with the engine idle and the FIFO empty → empty=0 after N, serialOut=0 and run=1 after edge N+1.
- All outputs are registered.
- full/empty are registered. A push into a full FIFO is refused even if a pop happens in the same cycle. Push and pop in the same cycle on a non-empty, non-full FIFO keeps the occupancy unchanged.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is kept in a counter one bit wider than the pointers.
- The frame length without error is (DATA_WIDTH+3+stopBit2)·ETU cycles.

## Configuration
- ISO_TX_ERROR_SIGNAL_EN defined: serialIn sampling, the ERRWAIT state, the retry counter and txError are compiled in.
- ISO_TX_ERROR_SIGNAL_EN undefined: serialIn is ignored and txError is tied to 0. Every frame pops at STOP end, and ERRWAIT is unreachable.

## Structure
- Package iso_tx_pkg holds:
  - the FSM state enum;
  - a clog2-based width function;
  - the ETU sample-point constant.
- Sub-module iso_tx_fifo: synchronous FIFO with DATA_WIDTH and FIFO_DEPTH parameters, push/pop/full/empty/head ports.
- The top level holds the FSM, ETU counter, bit counter, shift register, parity and retry logic.

## Test plan
- Basic frame: clocksPerBit=7, oddParity=0, msbFirst=0, dataIn=8'h80 loaded once → serialOut per 8-cycle ETU is 0,0,0,0,0,0,0,0,1,1,1. Frame is 88 cycles; run drops afterwards.
- Back-to-back: load 8'h80 then 8'h7F in consecutive cycles → two frames with no idle gap. The second frame's parity bit is 1, and empty=1 after the second pop.
- FIFO boundary: FIFO_DEPTH=4, hold loadDataIn for 6 cycles while idle → only 4 writes are accepted, full=1, and the extra data is not transmitted.
- Error repeat (macro defined): drive serialIn=0 for 1 ETU at the first-STOP sample point of the frame for 8'hA5 → ERRWAIT for 2 ETUs, then 8'hA5 is resent identically.
- Retry exhaustion: force the error on 4 consecutive frames, MAX_RETRIES=3 → 4 transmissions, a one-cycle txError pulse, the FIFO is popped and the next character starts.
- Reset mid-DATA: assert nReset=0 during bit 3 → serialOut=1, run=0, empty=1 immediately. After release there is no transmission until a new load.
